// File: rtl/tea_core_arbiter.sv
// Round-robin front end that shares one TEA cipher core between two requesters.
// One operation in flight; the core is started with a pulse and guarded by a watchdog.
module tea_core_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int MAX_LATENCY = 40,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   iReq0Valid,
    output logic                   oReq0Ready,
    input  logic [2*WORD_SIZE-1:0] iReq0V,
    input  logic [4*WORD_SIZE-1:0] iReq0Key,
    output logic                   oRsp0Valid,
    input  logic                   iRsp0Ready,
    output logic [2*WORD_SIZE-1:0] oRsp0C,
    output logic                   oRsp0Err,

    input  logic                   iReq1Valid,
    output logic                   oReq1Ready,
    input  logic [2*WORD_SIZE-1:0] iReq1V,
    input  logic [4*WORD_SIZE-1:0] iReq1Key,
    output logic                   oRsp1Valid,
    input  logic                   iRsp1Ready,
    output logic [2*WORD_SIZE-1:0] oRsp1C,
    output logic                   oRsp1Err,

    output logic                   oCoreStart,
    output logic [2*WORD_SIZE-1:0] oCoreV,
    output logic [4*WORD_SIZE-1:0] oCoreKey,
    input  logic [2*WORD_SIZE-1:0] iCoreC,
    input  logic                   iCoreDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MAX_LATENCY - 1);

    state_t               state;
    logic                 last_grant;
    logic                 owner;
    logic [CNT_WIDTH-1:0] wd_cnt;

    logic grant_sel;
    logic accept;
    logic done_seen;
    logic owner_rsp_ready;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        grant_sel       = iReq1Valid & (~iReq0Valid | ~last_grant);
        oReq0Ready      = (state == IDLE) & iReq0Valid & ~grant_sel;
        oReq1Ready      = (state == IDLE) & iReq1Valid & grant_sel;
        accept          = oReq0Ready | oReq1Ready;
        // A count of zero means first WAIT cycle: done may still be the previous op's.
        done_seen       = iCoreDone & (wd_cnt != '0);
        owner_rsp_ready = owner ? iRsp1Ready : iRsp0Ready;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wd_cnt     <= '0;
            oCoreStart <= 1'b0;
            oCoreV     <= '0;
            oCoreKey   <= '0;
            oRsp0Valid <= 1'b0;
            oRsp0C     <= '0;
            oRsp0Err   <= 1'b0;
            oRsp1Valid <= 1'b0;
            oRsp1C     <= '0;
            oRsp1Err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        oCoreV     <= grant_sel ? iReq1V : iReq0V;
                        oCoreKey   <= grant_sel ? iReq1Key : iReq0Key;
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        oCoreStart <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    oCoreStart <= 1'b0;
                    wd_cnt     <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (done_seen) begin
                        if (owner) begin
                            oRsp1C     <= iCoreC;
                            oRsp1Err   <= 1'b0;
                            oRsp1Valid <= 1'b1;
                        end else begin
                            oRsp0C     <= iCoreC;
                            oRsp0Err   <= 1'b0;
                            oRsp0Valid <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wd_cnt == TIMEOUT_CNT) begin
                        if (owner) begin
                            oRsp1C     <= '0;
                            oRsp1Err   <= 1'b1;
                            oRsp1Valid <= 1'b1;
                        end else begin
                            oRsp0C     <= '0;
                            oRsp0Err   <= 1'b1;
                            oRsp0Valid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Response registers return to zero so idle ports never show stale data.
                    if (owner_rsp_ready) begin
                        oRsp0Valid <= 1'b0;
                        oRsp0C     <= '0;
                        oRsp0Err   <= 1'b0;
                        oRsp1Valid <= 1'b0;
                        oRsp1C     <= '0;
                        oRsp1Err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_core_arbiter.sv
// Directed bench for tea_core_arbiter with a behavioural XOR core that completes 33 cycles after start.
module tb_tea_core_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           iReq0Valid = 1'b0, iReq1Valid = 1'b0;
    logic           oReq0Ready, oReq1Ready;
    logic [2*W-1:0] iReq0V = '0, iReq1V = '0;
    logic [4*W-1:0] iReq0Key = '0, iReq1Key = '0;
    logic           oRsp0Valid, oRsp1Valid;
    logic           iRsp0Ready = 1'b0, iRsp1Ready = 1'b0;
    logic [2*W-1:0] oRsp0C, oRsp1C;
    logic           oRsp0Err, oRsp1Err;
    logic           oCoreStart;
    logic [2*W-1:0] oCoreV;
    logic [4*W-1:0] oCoreKey;
    logic [2*W-1:0] core_c = '0;
    logic           core_done = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tea_core_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .iReq0Valid (iReq0Valid),
        .oReq0Ready (oReq0Ready),
        .iReq0V     (iReq0V),
        .iReq0Key   (iReq0Key),
        .oRsp0Valid (oRsp0Valid),
        .iRsp0Ready (iRsp0Ready),
        .oRsp0C     (oRsp0C),
        .oRsp0Err   (oRsp0Err),
        .iReq1Valid (iReq1Valid),
        .oReq1Ready (oReq1Ready),
        .iReq1V     (iReq1V),
        .iReq1Key   (iReq1Key),
        .oRsp1Valid (oRsp1Valid),
        .iRsp1Ready (iRsp1Ready),
        .oRsp1C     (oRsp1C),
        .oRsp1Err   (oRsp1Err),
        .oCoreStart (oCoreStart),
        .oCoreV     (oCoreV),
        .oCoreKey   (oCoreKey),
        .iCoreC     (core_c),
        .iCoreDone  (core_done)
    );

    // Core model: done drops one cycle after start is seen, rises 33 cycles after start.
    int  m_cnt      = 0;
    bit  start_d    = 1'b0;
    bit  never_done = 1'b0;

    always @(posedge clk) begin
        start_d <= oCoreStart;
        if (start_d) core_done <= 1'b0;
        if (oCoreStart) begin
            m_cnt <= 33;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !never_done) begin
                core_done <= 1'b1;
                core_c    <= {oCoreV[63:32] ^ oCoreKey[127:96], oCoreV[31:0] ^ oCoreKey[95:64]};
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic who, input logic [63:0] v, input logic [127:0] key, input bit keep);
        if (who) begin
            iReq1V = v; iReq1Key = key; iReq1Valid = 1'b1;
        end else begin
            iReq0V = v; iReq0Key = key; iReq0Valid = 1'b1;
        end
        #1;
        check("grant_ready", who ? oReq1Ready : oReq0Ready, 1'b1);
        check("other_ready", who ? oReq0Ready : oReq1Ready, 1'b0);
        tick();
        check("core_start", oCoreStart, 1'b1);
        check("core_v", oCoreV, v);
        check("core_key", oCoreKey, key);
        check("ready_after_accept", oReq0Ready | oReq1Ready, 1'b0);
        if (!keep) begin
            iReq0Valid = 1'b0;
            iReq1Valid = 1'b0;
        end
    endtask

    // Called right after the accept edge; lat counts edges until the response is visible.
    task automatic wait_rsp(input logic who, input int lat, input logic [63:0] exp_c, input logic exp_err);
        int   n          = 0;
        logic got        = 1'b0;
        logic other_seen = 1'b0;
        while (!got && n < 80) begin
            tick();
            n++;
            if (n == 1) check("start_pulse_end", oCoreStart, 1'b0);
            if (who ? oRsp0Valid : oRsp1Valid) other_seen = 1'b1;
            got = who ? oRsp1Valid : oRsp0Valid;
        end
        check("rsp_latency", n, lat);
        check("rsp_c", who ? oRsp1C : oRsp0C, exp_c);
        check("rsp_err", who ? oRsp1Err : oRsp0Err, exp_err);
        check("other_valid", other_seen, 1'b0);
        check("other_c", who ? oRsp0C : oRsp1C, 64'h0);
        if (who) iRsp1Ready = 1'b1; else iRsp0Ready = 1'b1;
        tick();
        check("rsp_drop", who ? oRsp1Valid : oRsp0Valid, 1'b0);
        iRsp0Ready = 1'b0;
        iRsp1Ready = 1'b0;
    endtask

    localparam logic [63:0]  V_A = 64'h3d45f7a7_235fcb21;
    localparam logic [127:0] K_A = 128'h132acf42_234acb45_3235acbe_4533f235;
    localparam logic [63:0]  C_A = 64'h2e6f38e5_00150064;
    localparam logic [63:0]  V_B = 64'h01234567_89abcdef;
    localparam logic [127:0] K_B = 128'hffff0000_0f0f0f0f_00000000_00000000;
    localparam logic [63:0]  C_B = 64'hfedc4567_86a4c2e0;
    localparam logic [63:0]  V_C = 64'ha5a5a5a5_5a5a5a5a;
    localparam logic [127:0] K_C = 128'hffffffff_00000000_12345678_9abcdef0;
    localparam logic [63:0]  C_C = 64'h5a5a5a5a_5a5a5a5a;
    localparam logic [63:0]  V_D = 64'hdeadbeef_cafef00d;
    localparam logic [127:0] K_D = 128'h00000000_ffffffff_00000001_00000002;
    localparam logic [63:0]  C_D = 64'hdeadbeef_35010ff2;

    initial begin
        int   n;
        logic seen;

        // Reset values
        tick();
        tick();
        check("rst_start", oCoreStart, 1'b0);
        check("rst_core_v", oCoreV, 64'h0);
        check("rst_core_key", oCoreKey, 128'h0);
        check("rst_rsp_valid", {oRsp0Valid, oRsp1Valid, oRsp0Err, oRsp1Err}, 4'b0);
        check("rst_rsp_c", {oRsp0C, oRsp1C}, 128'h0);
        rst = 1'b1;
        tick();

        // Single request from requester 0
        issue(1'b0, V_A, K_A, 1'b0);
        wait_rsp(1'b0, 35, C_A, 1'b0);

        // Response backpressure with requester 1 waiting
        issue(1'b0, V_A, K_A, 1'b0);
        iReq1V = V_B; iReq1Key = K_B; iReq1Valid = 1'b1;
        n = 0;
        while (!oRsp0Valid && n < 80) begin
            tick();
            n++;
        end
        check("bp_latency", n, 35);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_held", oRsp0Valid, 1'b1);
            check("bp_c_held", oRsp0C, C_A);
            check("bp_ready1_low", oReq1Ready, 1'b0);
        end
        iRsp0Ready = 1'b1;
        #1;
        check("bp_ready1_in_handshake", oReq1Ready, 1'b0);
        tick();
        iRsp0Ready = 1'b0;
        check("bp_valid_drop", oRsp0Valid, 1'b0);
        check("bp_ready1_after", oReq1Ready, 1'b1);
        tick();
        check("bp_req1_start", oCoreStart, 1'b1);
        check("bp_req1_v", oCoreV, V_B);
        iReq1Valid = 1'b0;
        wait_rsp(1'b1, 35, C_B, 1'b0);

        // Contention: both held valid, grants alternate 0,1,0,1
        iReq0V = V_C; iReq0Key = K_C; iReq0Valid = 1'b1;
        iReq1V = V_C; iReq1Key = K_C; iReq1Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'(i % 2), V_C, K_C, 1'b1);
            wait_rsp(1'(i % 2), 35, C_C, 1'b0);
        end
        iReq0Valid = 1'b0;
        iReq1Valid = 1'b0;

        // Watchdog timeout, then a normal operation
        never_done = 1'b1;
        issue(1'b0, 64'h11111111_22222222, 128'h33333333_44444444_00000000_00000000, 1'b0);
        wait_rsp(1'b0, 41, 64'h0, 1'b1);
        never_done = 1'b0;
        issue(1'b1, V_D, K_D, 1'b0);
        wait_rsp(1'b1, 35, C_D, 1'b0);

        // Asynchronous reset in the middle of WAIT
        issue(1'b0, V_B, K_B, 1'b0);
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_start", oCoreStart, 1'b0);
        check("arst_core_v", oCoreV, 64'h0);
        check("arst_core_key", oCoreKey, 128'h0);
        check("arst_rsp", {oRsp0Valid, oRsp1Valid, oRsp0Err, oRsp1Err}, 4'b0);
        tick();
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (oRsp0Valid || oRsp1Valid) seen = 1'b1;
        end
        check("arst_no_rsp", seen, 1'b0);
        iReq0V = V_A; iReq0Key = K_A; iReq0Valid = 1'b1;
        iReq1V = V_D; iReq1Key = K_D; iReq1Valid = 1'b1;
        #1;
        check("arst_grant0", oReq0Ready, 1'b1);
        check("arst_not_grant1", oReq1Ready, 1'b0);
        tick();
        check("arst_start_pulse", oCoreStart, 1'b1);
        check("arst_core_v_new", oCoreV, V_A);
        iReq0Valid = 1'b0;
        iReq1Valid = 1'b0;
        wait_rsp(1'b0, 35, C_A, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
